// File: rtl/reset_sequencer_pkg.sv
// Shared state encodings and default parameter values for the reset sequencer.
package reset_sequencer_pkg;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STRETCH_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2,
    ST_SW_RST  = 2'd3
  } state_t;

endpackage

// File: rtl/reset_sequencer_sync.sv
// Asynchronous-assert, synchronous-deassert reset chain.
module reset_sync
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_rstn_sync
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_rstn_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes and stretches the board reset, and services
// software reset requests and hold with registered, glitch-free reset outputs.
//
// state      | meaning
// ST_SYNC    | waiting for the synchronized reset to deassert
// ST_STRETCH | holding reset for STRETCH_CYCLES after synchronization
// ST_RUN     | reset released, downstream logic running
// ST_SW_RST  | software- or hold-initiated reset in progress
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_sw_rst_req,
  input  logic       i_hold,
  output logic       o_rstn,
  output logic       o_rst,
  output logic       o_sw_rst_ack,
  output logic [1:0] o_state
);

  localparam int               CNT_W    = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_d;
  logic             req_edge;
  logic             sw_pending;
  logic             rstn_sync;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .o_rstn_sync(rstn_sync)
  );

  assign req_edge = i_sw_rst_req & ~req_d;
  assign o_state  = state;

  // req_d resets high so a request already asserted at reset release is not
  // mistaken for a fresh edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= ST_SYNC;
      cnt          <= '0;
      req_d        <= 1'b1;
      sw_pending   <= 1'b0;
      o_rstn       <= 1'b0;
      o_rst        <= 1'b1;
      o_sw_rst_ack <= 1'b0;
    end else begin
      req_d        <= i_sw_rst_req;
      o_sw_rst_ack <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (rstn_sync) begin
            state <= ST_STRETCH;
            cnt   <= '0;
          end
        end
        ST_STRETCH, ST_SW_RST: begin
          if (i_hold) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= ST_RUN;
            cnt          <= '0;
            o_rstn       <= 1'b1;
            o_rst        <= 1'b0;
            o_sw_rst_ack <= sw_pending;
            sw_pending   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // A request edge wins over hold so the requester still gets its ack.
          if (req_edge || i_hold) begin
            state      <= ST_SW_RST;
            cnt        <= '0;
            sw_pending <= req_edge;
            o_rstn     <= 1'b0;
            o_rst      <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor compares them and checks output invariants every cycle.
module tb_reset_sequencer;

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_STR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_SW   = 2'd3;

  typedef struct {
    int         cyc;
    logic       rstn;
    logic       ack;
    logic [1:0] st;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req;
  logic       hold;
  logic       o_rstn;
  logic       o_rst;
  logic       o_ack;
  logic [1:0] o_state;

  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   soak    = 1'b0;
  exp_t exp_q[$];
  int   ack_q[$];
  logic [1:0] prev_st   = 2'd0;
  logic       prev_rstn = 1'b0;

  reset_sequencer #(
    .SYNC_STAGES   (2),
    .STRETCH_CYCLES(4)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_sw_rst_req(req),
    .i_hold      (hold),
    .o_rstn      (o_rstn),
    .o_rst       (o_rst),
    .o_sw_rst_ack(o_ack),
    .o_state     (o_state)
  );

  initial begin
    #2;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
  endtask

  task automatic exp_push(input int d, input logic [1:0] st, input logic ack, input string tag);
    exp_t e;
    e.cyc  = cyc + d;
    e.rstn = (st == S_RUN);
    e.ack  = ack;
    e.st   = st;
    e.tag  = tag;
    exp_q.push_back(e);
    if (ack) ack_q.push_back(cyc + d);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_async_reset(input string tag);
    check({tag, "_rstn"},  {31'd0, o_rstn},  32'd0);
    check({tag, "_rst"},   {31'd0, o_rst},   32'd1);
    check({tag, "_state"}, {30'd0, o_state}, {30'd0, S_SYNC});
    check({tag, "_ack"},   {31'd0, o_ack},   32'd0);
  endtask

  always @(negedge clk) begin : monitor
    logic inv_rst;
    logic run_now;
    bit   found;
    inv_rst = ~o_rstn;
    run_now = (o_state == S_RUN);
    check("rst_is_not_rstn", {31'd0, o_rst}, {31'd0, inv_rst});
    check("rstn_only_in_run", {31'd0, o_rstn}, {31'd0, run_now});
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc < cyc) begin
        n_total++;
        $display("FAIL %s missed: expected at cycle %0d, now %0d", exp_q[i].tag, exp_q[i].cyc, cyc);
        exp_q.delete(i);
      end else if (exp_q[i].cyc == cyc) begin
        check({exp_q[i].tag, "_state"}, {30'd0, o_state}, {30'd0, exp_q[i].st});
        check({exp_q[i].tag, "_rstn"}, {31'd0, o_rstn}, {31'd0, exp_q[i].rstn});
        check({exp_q[i].tag, "_ack"}, {31'd0, o_ack}, {31'd0, exp_q[i].ack});
        exp_q.delete(i);
      end
    end
    if (o_ack) begin
      check("ack_follows_sw_rst", {28'd0, prev_st, prev_rstn, run_now},
            {28'd0, S_SW, 1'b0, 1'b1});
      if (!soak) begin
        found = 1'b0;
        for (int i = ack_q.size() - 1; i >= 0; i--) begin
          if (ack_q[i] == cyc) begin
            found = 1'b1;
            ack_q.delete(i);
          end
        end
        check("ack_expected", {31'd0, found}, 32'd1);
      end
    end
    prev_st   = o_state;
    prev_rstn = o_rstn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    req  = 1'b0;
    hold = 1'b0;
    exp_push(1, S_SYNC, 1'b0, "por_in_reset");
    exp_push(3, S_SYNC, 1'b0, "por_in_reset_late");

    // power-on release 3 ns after the edge at 37 ns
    #40;
    rstn = 1'b1;
    exp_push(2, S_SYNC, 1'b0, "por_sync");
    exp_push(3, S_STR,  1'b0, "por_stretch_enter");
    exp_push(6, S_STR,  1'b0, "por_edge6_low");
    exp_push(7, S_RUN,  1'b0, "por_edge7_run");
    step(10);

    // single-cycle software request
    req = 1'b1;
    exp_push(1, S_SW,  1'b0, "pulse_enter");
    exp_push(4, S_SW,  1'b0, "pulse_last_low");
    exp_push(5, S_RUN, 1'b1, "pulse_ack");
    exp_push(6, S_RUN, 1'b0, "pulse_ack_gone");
    step(1);
    req = 1'b0;
    step(8);

    // request held for 20 cycles: one reset, one ack
    req = 1'b1;
    exp_push(1,  S_SW,  1'b0, "held_enter");
    exp_push(4,  S_SW,  1'b0, "held_last_low");
    exp_push(5,  S_RUN, 1'b1, "held_ack");
    exp_push(6,  S_RUN, 1'b0, "held_ack_gone");
    exp_push(19, S_RUN, 1'b0, "held_no_second");
    step(20);
    req = 1'b0;
    exp_push(2, S_RUN, 1'b0, "held_release");
    step(4);

    // second edge while in ST_SW_RST is dropped
    req = 1'b1;
    exp_push(1, S_SW,  1'b0, "dbl_enter");
    exp_push(5, S_RUN, 1'b1, "dbl_ack");
    exp_push(6, S_RUN, 1'b0, "dbl_after");
    exp_push(9, S_RUN, 1'b0, "dbl_no_requeue");
    step(1);
    req = 1'b0;
    step(1);
    req = 1'b1;
    step(1);
    req = 1'b0;
    step(8);

    // hold in RUN: reset without ack
    hold = 1'b1;
    exp_push(1, S_SW,  1'b0, "hold_run_enter");
    exp_push(4, S_SW,  1'b0, "hold_run_low");
    exp_push(5, S_RUN, 1'b0, "hold_run_no_ack");
    exp_push(6, S_RUN, 1'b0, "hold_run_after");
    step(1);
    hold = 1'b0;
    step(8);

    // edge and hold in the same RUN cycle: edge wins, ack given
    req  = 1'b1;
    hold = 1'b1;
    exp_push(1, S_SW,  1'b0, "prio_enter");
    exp_push(5, S_RUN, 1'b1, "prio_ack");
    step(1);
    req  = 1'b0;
    hold = 1'b0;
    step(8);

    // async assert in RUN, request high across release, hold from stretch count 2
    rstn = 1'b0;
    req  = 1'b1;
    #1;
    check_async_reset("async_run");
    step(1);
    rstn = 1'b1;
    exp_push(2,  S_SYNC, 1'b0, "hold_por_sync");
    exp_push(3,  S_STR,  1'b0, "hold_por_stretch");
    exp_push(7,  S_STR,  1'b0, "hold_por_extended");
    exp_push(11, S_STR,  1'b0, "hold_por_last_low");
    exp_push(12, S_RUN,  1'b0, "hold_por_run");
    exp_push(16, S_RUN,  1'b0, "no_false_req");
    step(5);
    hold = 1'b1;
    step(3);
    hold = 1'b0;
    step(10);
    req = 1'b0;
    step(3);

    // async assert during ST_SW_RST aborts with no ack
    req = 1'b1;
    exp_push(1, S_SW, 1'b0, "abort_enter");
    step(1);
    req = 1'b0;
    step(1);
    rstn = 1'b0;
    #1;
    check_async_reset("async_swrst");
    step(1);
    rstn = 1'b1;
    exp_push(3, S_STR, 1'b0, "abort_restretch");
    exp_push(7, S_RUN, 1'b0, "abort_run_no_ack");
    exp_push(8, S_RUN, 1'b0, "abort_after");
    step(10);

    // random soak
    soak = 1'b1;
    repeat (100) begin
      rstn = ($urandom_range(0, 15) != 0);
      req  = $urandom_range(0, 1) != 0;
      hold = ($urandom_range(0, 7) == 0);
      step(1);
    end
    rstn = 1'b1;
    req  = 1'b0;
    hold = 1'b0;
    step(12);
    soak = 1'b0;
    exp_push(1, S_RUN, 1'b0, "soak_recovered");
    step(3);

    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("ack_queue_drained", ack_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
